// File: rtl/lamp_safety_monitor.sv
// Lamp safety monitor: passes legal light commands to the lamp drivers one cycle late,
// and on any unsafe command pattern drops into an all-red flash until an operator clears it,
// followed by a solid all-red recovery period before normal operation resumes.
module lamp_safety_monitor #(
  parameter int unsigned FLASH_HALF     = 8,
  parameter int unsigned MIN_YELLOW     = 3,
  parameter int unsigned RECOVER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ns_light,
  input  logic [1:0] ew_light,
  input  logic [1:0] sn_light,
  input  logic [1:0] we_light,
  input  logic       clear_fault,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic [2:0] sn_lamp,
  output logic [2:0] we_lamp,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_count
);

  localparam logic [1:0] Red     = 2'b00;
  localparam logic [1:0] Green   = 2'b01;
  localparam logic [1:0] Yellow  = 2'b10;
  localparam logic [1:0] Illegal = 2'b11;

  localparam logic [2:0] LampRed = 3'b100;
  localparam logic [2:0] LampOff = 3'b000;

  // Flash counter spans one full on/off period; recover counter spans the recovery window.
  localparam int unsigned FlashW = $clog2(2 * FLASH_HALF);
  localparam int unsigned RecW   = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic [1:0] {StNormal, StFault, StRecover} state_e;

  state_e            state_q, state_d;
  logic [3:0][1:0]   light;
  logic [3:0][1:0]   prev_q, prev_d;
  logic [3:0][2:0]   ycnt_q, ycnt_d;
  logic [3:0][2:0]   lamp_q, lamp_d;
  logic [FlashW-1:0] flash_q, flash_d;
  logic [RecW-1:0]   rec_q, rec_d;
  logic              fault_q, fault_d;
  logic [2:0]        fcode_q, fcode_d;
  logic [7:0]        fcnt_q, fcnt_d;

  logic       any_illegal, conflict, bad_trans, short_yellow;
  logic [2:0] num_active;
  logic [2:0] code;

  // Index 0 is north-south; keeps per-direction logic in loops.
  assign light = {we_light, sn_light, ew_light, ns_light};

  function automatic logic [2:0] decode(input logic [1:0] l);
    case (l)
      Green:   decode = 3'b001;
      Yellow:  decode = 3'b010;
      default: decode = LampRed;
    endcase
  endfunction

  // Safety checks on the current sample against the previous one.
  always_comb begin
    any_illegal  = 1'b0;
    bad_trans    = 1'b0;
    short_yellow = 1'b0;
    num_active   = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (light[i] == Illegal) any_illegal = 1'b1;
      if (light[i] != Red) num_active = num_active + 3'd1;
      if ((prev_q[i] == Green  && light[i] == Red)   ||
          (prev_q[i] == Yellow && light[i] == Green) ||
          (prev_q[i] == Red    && light[i] == Yellow)) begin
        bad_trans = 1'b1;
      end
      if (prev_q[i] == Yellow && light[i] != Yellow && 32'(ycnt_q[i]) < MIN_YELLOW) begin
        short_yellow = 1'b1;
      end
    end
    conflict = (num_active > 3'd1);
    // Lowest code wins when several checks fire together.
    if (any_illegal)       code = 3'd1;
    else if (conflict)     code = 3'd2;
    else if (bad_trans)    code = 3'd3;
    else if (short_yellow) code = 3'd4;
    else                   code = 3'd0;
  end

  // Next-state: history tracking plus the NORMAL / FAULT_FLASH / RECOVER sequencing.
  always_comb begin
    state_d = state_q;
    lamp_d  = lamp_q;
    flash_d = flash_q;
    rec_d   = rec_q;
    fcode_d = fcode_q;
    fcnt_d  = fcnt_q;
    prev_d  = light;
    for (int i = 0; i < 4; i++) begin
      if (light[i] == Yellow) ycnt_d[i] = (ycnt_q[i] == 3'd7) ? 3'd7 : ycnt_q[i] + 3'd1;
      else                    ycnt_d[i] = 3'd0;
    end

    case (state_q)
      StFault: begin
        if (clear_fault && !any_illegal && !conflict) begin
          state_d = StRecover;
          rec_d   = '0;
          lamp_d  = {4{LampRed}};
        end else begin
          flash_d = (flash_q == FlashW'(2 * FLASH_HALF - 1)) ? '0 : flash_q + 1'b1;
          lamp_d  = (32'(flash_d) < FLASH_HALF) ? {4{LampRed}} : {4{LampOff}};
        end
      end
      default: begin
        if (code != 3'd0) begin
          // Offending pattern is never shown: lamps go straight to red-on.
          state_d = StFault;
          lamp_d  = {4{LampRed}};
          flash_d = '0;
          fcode_d = code;
          if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
        end else if (state_q == StRecover) begin
          if (32'(rec_q) >= RECOVER_CYCLES - 1) begin
            state_d = StNormal;
            rec_d   = '0;
            for (int i = 0; i < 4; i++) lamp_d[i] = decode(light[i]);
          end else begin
            rec_d  = rec_q + 1'b1;
            lamp_d = {4{LampRed}};
          end
        end else begin
          for (int i = 0; i < 4; i++) lamp_d[i] = decode(light[i]);
        end
      end
    endcase

    fault_d = (state_d == StFault);
  end

  // State and registered outputs; reset forces all-red, cleared history and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StNormal;
      lamp_q  <= {4{LampRed}};
      prev_q  <= {4{Red}};
      ycnt_q  <= '0;
      flash_q <= '0;
      rec_q   <= '0;
      fault_q <= 1'b0;
      fcode_q <= 3'd0;
      fcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      lamp_q  <= lamp_d;
      prev_q  <= prev_d;
      ycnt_q  <= ycnt_d;
      flash_q <= flash_d;
      rec_q   <= rec_d;
      fault_q <= fault_d;
      fcode_q <= fcode_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign ns_lamp     = lamp_q[0];
  assign ew_lamp     = lamp_q[1];
  assign sn_lamp     = lamp_q[2];
  assign we_lamp     = lamp_q[3];
  assign fault       = fault_q;
  assign fault_code  = fcode_q;
  assign fault_count = fcnt_q;

endmodule

// File: doc/lamp_safety_monitor.md
LAMP_SAFETY_MONITOR -- requirements
Module: lamp_safety_monitor

Interface
REQ-001 SHALL have parameter FLASH_HALF, default 8, giving the flash half-period in clk cycles.
REQ-002 SHALL have parameter MIN_YELLOW, default 3, giving the minimum consecutive yellow cycles.
REQ-003 SHALL have parameter RECOVER_CYCLES, default 4, giving the solid all-red cycles before resuming.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports ns_light, ew_light, sn_light and we_light, each input, 2 bits: light command codes RED=00, GREEN=01, YELLOW=10; 11 is illegal.
REQ-007 SHALL have port clear_fault, input, 1 bit: operator request to leave the fault state.
REQ-008 SHALL have ports ns_lamp, ew_lamp, sn_lamp and we_lamp, each output, 3 bits {red,yellow,green}: registered lamp drives.
REQ-009 SHALL have port fault, output, 1 bit: high while in FAULT_FLASH.
REQ-010 SHALL have port fault_code, output, 3 bits: code of the most recent fault, sticky.
REQ-011 SHALL have port fault_count, output, 8 bits: number of FAULT_FLASH entries, saturating at 255.

Function
REQ-012 SHALL implement states NORMAL, FAULT_FLASH and RECOVER.
REQ-013 SHALL, in NORMAL, register each input decode onto its lamp one cycle later: RED->100, YELLOW->010, GREEN->001.
REQ-014 SHALL flag fault code 1 when any input equals 11 in the current cycle.
REQ-015 SHALL flag fault code 2 when more than one input is non-RED in the same cycle.
REQ-016 SHALL flag fault code 3 on any per-direction transition GREEN->RED, YELLOW->GREEN or RED->YELLOW, compared against the previous cycle's sample.
REQ-017 SHALL flag fault code 4 when a direction leaves YELLOW with its yellow counter below MIN_YELLOW.
REQ-018 SHALL keep one 3-bit yellow counter per direction, holding the number of consecutive prior samples at YELLOW, saturating at 7 and cleared when the sample is non-YELLOW.
REQ-019 SHALL update the previous-sample registers and yellow counters every cycle in every state.
REQ-020 SHALL evaluate the checks in NORMAL and RECOVER only, and ignore them in FAULT_FLASH.
REQ-021 SHALL, when several checks fire in the same cycle, report the lowest code.
REQ-022 SHALL, on any fault in NORMAL or RECOVER, go to FAULT_FLASH at that edge.
REQ-023 SHALL, at that same edge, load fault_code, increment fault_count and reset the flash counter to 0.
REQ-024 SHALL never present the offending input pattern on the lamps.
REQ-025 SHALL, in FAULT_FLASH, drive every lamp to 100 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating, starting with red-on at the entry edge.
REQ-026 SHALL leave FAULT_FLASH for RECOVER only when clear_fault=1 and neither code 1 nor code 2 is currently true.
REQ-027 SHALL ignore clear_fault in NORMAL and RECOVER.
REQ-028 SHALL, in RECOVER, drive all lamps solid 100 for RECOVER_CYCLES cycles and then enter NORMAL.
REQ-029 SHALL, when a fault occurs in RECOVER, abort recovery and re-enter FAULT_FLASH.
REQ-030 SHALL have the first NORMAL cycle after RECOVER register the current input decode.

Reset
REQ-031 SHALL, while rst_n=0, force state NORMAL and all lamps to 100.
REQ-032 SHALL, while rst_n=0, clear fault, fault_code, fault_count, the flash counter and the recover counter to 0.
REQ-033 SHALL, while rst_n=0, set all previous-sample registers to RED and all yellow counters to 0.
REQ-034 SHALL allow reset asserted in any state, including mid-flash or mid-recovery, to take effect immediately without waiting for clk.
REQ-035 SHALL have the first edge after rst_n rises treat RED->GREEN as legal.

Verification
REQ-036 SHALL cover legal cycling: ns=GREEN for 11 cycles, then YELLOW for 4 -> ns_lamp=001, then 010, each one cycle late; fault=0.
REQ-037 SHALL cover a conflict: ns=01 and ew=01 in one cycle -> next edge fault=1, fault_code=2, all lamps 100, fault_count=1.
REQ-038 SHALL cover short yellow: ew YELLOW for 2 cycles, then RED -> fault_code=4.
REQ-039 SHALL cover code priority: ns=11 and ew=01 and sn=01 together -> fault_code=1, not 2.
REQ-040 SHALL cover flash and clear: in FAULT_FLASH, lamps are 100 for 8 cycles then 000 for 8; with clear_fault=1 and only sn=GREEN -> 4 cycles of all 100, then sn_lamp=001.
REQ-041 SHALL cover fault in recovery and reset: ns GREEN->RED during RECOVER -> FAULT_FLASH with code 3 and fault_count=2; rst_n=0 mid-flash -> outputs return to reset values asynchronously.
